// File: rtl/calc_keypad_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_keypad_sequencer
// Purpose  : Keypad front end for the calculator datapath. Converts level key
//            inputs into single-cycle press events and steps an entry FSM
//            (operand A -> operator -> operand B -> equals). It drives the
//            datapath operands, operator and result request, with explicit
//            error and clear handling.
// Ports    : clk          - single clock, rising-edge
//            rst          - asynchronous active-high reset
//            digit_keys   - level digit keys, bit i = digit i (synchronised)
//            func_key     - level operator key
//            func_code    - operator code, sampled on a func_key press
//            eq_key       - level equals key
//            clr_key      - level clear key
//            input_a      - operand A to datapath (registered)
//            input_b      - operand B to datapath (registered)
//            func         - operator to datapath (registered)
//            get_res      - result request (registered level)
//            err          - high while in the error state
//            state        - current FSM state encoding (debug)
// Revision : 1.0 - initial release
// ============================================================================
module calc_keypad_sequencer #(
    parameter logic [2:0] FUNC_MAX = 3'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] digit_keys,
    input  logic       func_key,
    input  logic [2:0] func_code,
    input  logic       eq_key,
    input  logic       clr_key,
    output logic [3:0] input_a,
    output logic [3:0] input_b,
    output logic [2:0] func,
    output logic       get_res,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_OP  = 3'd1,
        S_B   = 3'd2,
        S_RDY = 3'd3,
        S_RES = 3'd4,
        S_ERR = 3'd5
    } state_t;

    localparam logic [2:0] c_func_div = 3'd3;

    state_t     state_q, state_d;
    logic [3:0] input_a_q, input_a_d;
    logic [3:0] input_b_q, input_b_d;
    logic [2:0] func_q, func_d;
    logic       get_res_q, get_res_d;
    logic       err_q, err_d;

    // Previous key levels; reset to all-ones so a key held through reset
    // must be released and pressed again before it counts.
    logic [9:0] digit_prev_q;
    logic       func_prev_q;
    logic       eq_prev_q;
    logic       clr_prev_q;

    logic       w_digit_onehot;
    logic       w_digit_press;
    logic [3:0] w_digit_val;
    logic       w_func_press;
    logic       w_eq_press;
    logic       w_clr_press;
    logic       w_func_legal;

    // ------------------------------------------------------------------
    // Press detection
    // ------------------------------------------------------------------
    always_comb begin
        // Exactly one bit set: nonzero and clearing the lowest set bit
        // leaves nothing behind.
        w_digit_onehot = (digit_keys != 10'd0) &&
                         ((digit_keys & (digit_keys - 10'd1)) == 10'd0);
        // A digit press must start from all keys released; shrinking a
        // multi-hot pattern down to one key does not count.
        w_digit_press  = (digit_prev_q == 10'd0) && w_digit_onehot;
        w_func_press   = func_key & ~func_prev_q;
        w_eq_press     = eq_key   & ~eq_prev_q;
        w_clr_press    = clr_key  & ~clr_prev_q;
        w_func_legal   = (func_code <= FUNC_MAX);

        w_digit_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (digit_keys[i]) begin
                w_digit_val = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM: next state and register next values
    // Priority of coincident presses: clr > eq > func > digit.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        input_a_d = input_a_q;
        input_b_d = input_b_q;
        func_d    = func_q;

        if (w_clr_press) begin
            state_d   = S_A;
            input_a_d = 4'd0;
            input_b_d = 4'd0;
            func_d    = 3'd0;
        end else begin
            case (state_q)
                S_A: begin
                    if (!w_eq_press && !w_func_press && w_digit_press) begin
                        input_a_d = w_digit_val;
                        state_d   = S_OP;
                    end
                end
                S_OP: begin
                    if (w_eq_press) begin
                        // ignored, but still masks lower-priority presses
                    end else if (w_func_press) begin
                        if (w_func_legal) begin
                            func_d  = func_code;
                            state_d = S_B;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (w_digit_press) begin
                        input_a_d = w_digit_val;
                    end
                end
                S_B: begin
                    if (w_eq_press) begin
                        // ignored
                    end else if (w_func_press) begin
                        if (w_func_legal) begin
                            func_d = func_code;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (w_digit_press) begin
                        input_b_d = w_digit_val;
                        state_d   = S_RDY;
                    end
                end
                S_RDY: begin
                    if (w_eq_press) begin
                        if ((func_q == c_func_div) && (input_b_q == 4'd0)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_RES;
                        end
                    end else if (w_func_press) begin
                        // ignored
                    end else if (w_digit_press) begin
                        input_b_d = w_digit_val;
                    end
                end
                S_RES: begin
                    // A new digit starts the next calculation from operand A.
                    if (!w_eq_press && !w_func_press && w_digit_press) begin
                        input_a_d = w_digit_val;
                        input_b_d = 4'd0;
                        state_d   = S_OP;
                    end
                end
                S_ERR: begin
                    // Only clear leaves the error state.
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end

        // Flag outputs follow the next state so they change on the same
        // edge as the state itself.
        get_res_d = (state_d == S_RES);
        err_d     = (state_d == S_ERR);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_A;
            input_a_q    <= 4'd0;
            input_b_q    <= 4'd0;
            func_q       <= 3'd0;
            get_res_q    <= 1'b0;
            err_q        <= 1'b0;
            digit_prev_q <= '1;
            func_prev_q  <= 1'b1;
            eq_prev_q    <= 1'b1;
            clr_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            input_a_q    <= input_a_d;
            input_b_q    <= input_b_d;
            func_q       <= func_d;
            get_res_q    <= get_res_d;
            err_q        <= err_d;
            digit_prev_q <= digit_keys;
            func_prev_q  <= func_key;
            eq_prev_q    <= eq_key;
            clr_prev_q   <= clr_key;
        end
    end

    assign input_a = input_a_q;
    assign input_b = input_b_q;
    assign func    = func_q;
    assign get_res = get_res_q;
    assign err     = err_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_keypad_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_keypad_sequencer
// Purpose  : Directed self-checking bench for calc_keypad_sequencer. Inputs
//            change 1 ns after a rising edge; outputs are checked 1 ns after
//            the edge that samples each press.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_keypad_sequencer;

    logic       clk;
    logic       rst;
    logic [9:0] digit_keys;
    logic       func_key;
    logic [2:0] func_code;
    logic       eq_key;
    logic       clr_key;
    logic [3:0] input_a;
    logic [3:0] input_b;
    logic [2:0] func;
    logic       get_res;
    logic       err;
    logic [2:0] state;

    int n_checks;
    int n_pass;

    calc_keypad_sequencer #(.FUNC_MAX(3'd5)) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_keys (digit_keys),
        .func_key   (func_key),
        .func_code  (func_code),
        .eq_key     (eq_key),
        .clr_key    (clr_key),
        .input_a    (input_a),
        .input_b    (input_b),
        .func       (func),
        .get_res    (get_res),
        .err        (err),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short; anything longer is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input int d);
        digit_keys = 10'(1 << d);
        tick();
        digit_keys = 10'd0;
        tick();
    endtask

    task automatic press_func(input logic [2:0] code);
        func_code = code;
        func_key  = 1'b1;
        tick();
        func_key  = 1'b0;
        tick();
    endtask

    task automatic press_eq();
        eq_key = 1'b1;
        tick();
        eq_key = 1'b0;
        tick();
    endtask

    task automatic press_clr();
        clr_key = 1'b1;
        tick();
        clr_key = 1'b0;
        tick();
    endtask

    task automatic check_all(input string tag, input logic [2:0] s, input logic [3:0] a,
                             input logic [3:0] b, input logic [2:0] f,
                             input logic g, input logic e);
        check({tag, ".state"},   8'(state),   8'(s));
        check({tag, ".input_a"}, 8'(input_a), 8'(a));
        check({tag, ".input_b"}, 8'(input_b), 8'(b));
        check({tag, ".func"},    8'(func),    8'(f));
        check({tag, ".get_res"}, 8'(get_res), 8'(g));
        check({tag, ".err"},     8'(err),     8'(e));
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        digit_keys = 10'd0;
        func_key   = 1'b0;
        func_code  = 3'd0;
        eq_key     = 1'b0;
        clr_key    = 1'b0;

        // ---------------- reset ----------------
        tick();
        tick();
        check_all("reset", 3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_after_reset.state", 8'(state), 8'd0);

        // keys ignored in S_A
        press_eq();
        check("sa_eq_ignored.state", 8'(state), 8'd0);
        press_func(3'd1);
        check_all("sa_func_ignored", 3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);

        // ---------------- basic 7 + 2 = ----------------
        press_digit(7);
        check("basic_a.state", 8'(state), 8'd1);
        check("basic_a.input_a", 8'(input_a), 8'd7);
        press_eq();
        check("sop_eq_ignored.state", 8'(state), 8'd1);
        press_func(3'd0);
        check("basic_op.state", 8'(state), 8'd2);
        check("basic_op.func", 8'(func), 8'd0);
        press_digit(2);
        check_all("basic_b", 3'd3, 4'd7, 4'd2, 3'd0, 1'b0, 1'b0);
        eq_key = 1'b1;
        check("eq_before_edge.get_res", 8'(get_res), 8'd0);
        tick();
        check_all("basic_res", 3'd4, 4'd7, 4'd2, 3'd0, 1'b1, 1'b0);
        eq_key = 1'b0;
        tick();
        check("res_held.get_res", 8'(get_res), 8'd1);

        // ---------------- chaining from S_RES ----------------
        press_digit(4);
        check_all("chain", 3'd1, 4'd4, 4'd0, 3'd0, 1'b0, 1'b0);

        // ---------------- overwrites ----------------
        press_digit(3);
        press_digit(5);
        check("sop_overwrite.input_a", 8'(input_a), 8'd5);
        check("sop_overwrite.state", 8'(state), 8'd1);
        press_func(3'd1);
        check("sb_func1.func", 8'(func), 8'd1);
        press_func(3'd2);
        check("sb_func2.func", 8'(func), 8'd2);
        check("sb_func2.state", 8'(state), 8'd2);

        // ---------------- key hygiene ----------------
        digit_keys = 10'h006;      // multi-hot from zero
        tick();
        check("multihot.state", 8'(state), 8'd2);
        digit_keys = 10'h002;      // narrowed to one-hot while still held
        tick();
        check("narrowed.state", 8'(state), 8'd2);
        check("narrowed.input_b", 8'(input_b), 8'd0);
        digit_keys = 10'd0;
        tick();
        digit_keys = 10'h004;      // hold digit 2 for 20 cycles
        tick();
        check("hold_first.state", 8'(state), 8'd3);
        check("hold_first.input_b", 8'(input_b), 8'd2);
        for (int i = 0; i < 19; i++) tick();
        digit_keys = 10'd0;
        tick();
        check("hold_end.input_b", 8'(input_b), 8'd2);
        check("hold_end.state", 8'(state), 8'd3);
        press_func(3'd4);
        check("srdy_func_ignored.func", 8'(func), 8'd2);
        press_digit(9);
        check("srdy_overwrite.input_b", 8'(input_b), 8'd9);
        press_eq();
        check("res2.state", 8'(state), 8'd4);

        // digit and clr in the same cycle: clr wins
        digit_keys = 10'h008;
        clr_key    = 1'b1;
        tick();
        check_all("clr_vs_digit", 3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        digit_keys = 10'd0;
        clr_key    = 1'b0;
        tick();

        // ---------------- divide by zero ----------------
        press_digit(8);
        press_func(3'd3);
        press_digit(0);
        check("div0_b.state", 8'(state), 8'd3);
        press_eq();
        check_all("div0", 3'd5, 4'd8, 4'd0, 3'd3, 1'b0, 1'b1);
        press_eq();
        press_digit(1);
        press_func(3'd0);
        check_all("err_ignore", 3'd5, 4'd8, 4'd0, 3'd3, 1'b0, 1'b1);
        press_clr();
        check_all("err_clr", 3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);

        // ---------------- illegal operators ----------------
        press_digit(1);
        press_func(3'd6);
        check("illegal_op.state", 8'(state), 8'd5);
        check("illegal_op.err", 8'(err), 8'd1);
        check("illegal_op.func", 8'(func), 8'd0);
        press_clr();
        press_digit(1);
        press_func(3'd5);
        check("legal_max.state", 8'(state), 8'd2);
        check("legal_max.func", 8'(func), 8'd5);
        press_func(3'd7);
        check("illegal_sb.state", 8'(state), 8'd5);
        press_clr();

        // ---------------- reset mid-operation with keys held ----------------
        press_digit(7);
        press_func(3'd0);
        press_digit(2);
        check("pre_rst.state", 8'(state), 8'd3);
        eq_key     = 1'b1;
        digit_keys = 10'h080;
        #1;
        rst = 1'b1;
        #1;
        check_all("async_rst", 3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("held_digit_thru_rst.state", 8'(state), 8'd0);
        check("held_digit_thru_rst.input_a", 8'(input_a), 8'd0);
        digit_keys = 10'd0;
        tick();
        press_digit(7);
        press_func(3'd0);
        press_digit(2);
        tick();
        check("held_eq.state", 8'(state), 8'd3);
        eq_key = 1'b0;
        tick();
        check("eq_released.state", 8'(state), 8'd3);
        press_eq();
        check("eq_toggled.state", 8'(state), 8'd4);
        check("eq_toggled.get_res", 8'(get_res), 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
